// File: rtl/mux_4x1_pkg.sv
// Shared constants for the 4:1 lane multiplexer: lane count and select encodings.
package mux_4x1_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_LANE0 = 2'd0;
    localparam sel_t SEL_LANE1 = 2'd1;
    localparam sel_t SEL_LANE2 = 2'd2;
    localparam sel_t SEL_LANE3 = 2'd3;

endpackage

// File: rtl/mux_4x1_mux_2x1.sv
// Lane-wide 2:1 multiplexer, the leaf cell of the 4:1 selection tree.
module mux_2x1 #(
    parameter int unsigned LANE_W = 1
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              s,
    output logic [LANE_W-1:0] y
);

    assign y = s ? b : a;

endmodule

// File: rtl/mux_4x1.sv
// 4:1 lane multiplexer built as a two-level 2:1 tree, with an optional output register
// (REG_OUT=1: one-cycle latency, holds on idle cycles) or a purely combinational path.
module mux_4x1
    import mux_4x1_pkg::*;
#(
    parameter int unsigned LANE_W  = 1,
    parameter int unsigned REG_OUT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES*LANE_W-1:0]   data,
    input  logic [1:0]                    sel,
    input  logic                          in_valid,
    output logic [LANE_W-1:0]             out,
    output logic                          out_valid
);

    logic [LANE_W-1:0] lane [NUM_LANES];
    logic [LANE_W-1:0] pair_lo;
    logic [LANE_W-1:0] pair_hi;
    logic [LANE_W-1:0] tree_y;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane[k] = data[k*LANE_W +: LANE_W];
    end

    // sel[0] picks within each pair, sel[1] picks between the pair results.
    mux_2x1 #(.LANE_W(LANE_W)) u_pair_lo (
        .a (lane[SEL_LANE0]),
        .b (lane[SEL_LANE1]),
        .s (sel[0]),
        .y (pair_lo)
    );

    mux_2x1 #(.LANE_W(LANE_W)) u_pair_hi (
        .a (lane[SEL_LANE2]),
        .b (lane[SEL_LANE3]),
        .s (sel[0]),
        .y (pair_hi)
    );

    mux_2x1 #(.LANE_W(LANE_W)) u_root (
        .a (pair_lo),
        .b (pair_hi),
        .s (sel[1]),
        .y (tree_y)
    );

    if (REG_OUT != 0) begin : g_reg
        logic [LANE_W-1:0] out_q;
        logic              valid_q;

        // Reset wins over a simultaneous qualified input; idle cycles hold the last result.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    out_q <= tree_y;
                end
            end
        end

        assign out       = out_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;

        // No state in this variant, so clock and reset are intentionally unused.
        assign unused_clk_rst = ^{clk, rst};
        assign out            = tree_y;
        assign out_valid      = in_valid;
    end

endmodule

// File: tb/tb_mux_4x1.sv
// Directed self-checking bench: registered 1-bit and 8-bit lanes plus a combinational variant.
module tb_mux_4x1;
    import mux_4x1_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  sel;
    logic        in_valid;
    logic [3:0]  data1;
    logic [31:0] data8;
    logic [3:0]  datac;
    logic        out1;
    logic        ov1;
    logic [7:0]  out8;
    logic        ov8;
    logic        outc;
    logic        ovc;

    int total = 0;
    int bad   = 0;

    logic [1:0] sel_seq [4];
    logic       exp1    [4];
    logic [7:0] exp8    [4];

    mux_4x1 #(.LANE_W(1), .REG_OUT(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .data      (data1),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out1),
        .out_valid (ov1)
    );

    mux_4x1 #(.LANE_W(8), .REG_OUT(1)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .data      (data8),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (out8),
        .out_valid (ov8)
    );

    mux_4x1 #(.LANE_W(1), .REG_OUT(0)) dutc (
        .clk       (clk),
        .rst       (rst),
        .data      (datac),
        .sel       (sel),
        .in_valid  (in_valid),
        .out       (outc),
        .out_valid (ovc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sel_seq[0] = SEL_LANE0; exp1[0] = 1'b0; exp8[0] = 8'hAA;
        sel_seq[1] = SEL_LANE1; exp1[1] = 1'b1; exp8[1] = 8'hBB;
        sel_seq[2] = SEL_LANE2; exp1[2] = 1'b0; exp8[2] = 8'hCC;
        sel_seq[3] = SEL_LANE3; exp1[3] = 1'b1; exp8[3] = 8'hDD;

        // Reset held for two edges with all-ones data and in_valid high.
        rst      = 1'b1;
        in_valid = 1'b1;
        sel      = 2'b00;
        data1    = 4'b1111;
        data8    = 32'hFFFF_FFFF;
        datac    = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out1", 32'(out1), 32'h0);
            check("rst_ov1", 32'(ov1), 32'h0);
            check("rst_out8", 32'(out8), 32'h0);
            check("rst_ov8", 32'(ov8), 32'h0);
            check("rst_comb_out", 32'(outc), 32'h1);
        end

        // Select stepped one per cycle, each result one cycle after sampling.
        rst   = 1'b0;
        data1 = 4'b1010;
        data8 = 32'hDDCC_BBAA;
        datac = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            sel = sel_seq[i];
            #1;
            check("comb_sel_out", 32'(outc), 32'(exp1[i]));
            check("comb_valid", 32'(ovc), 32'h1);
            step();
            check("sel_out1", 32'(out1), 32'(exp1[i]));
            check("sel_out8", 32'(out8), 32'(exp8[i]));
            check("sel_ov1", 32'(ov1), 32'h1);
            check("sel_ov8", 32'(ov8), 32'h1);
        end

        // Single qualified pulse, then idle with a new select: output holds.
        sel = 2'b01;
        step();
        check("pulse_out1", 32'(out1), 32'h1);
        check("pulse_ov1", 32'(ov1), 32'h1);
        in_valid = 1'b0;
        sel      = 2'b00;
        step();
        check("hold_out1", 32'(out1), 32'h1);
        check("hold_out8", 32'(out8), 32'hBB);
        check("hold_ov1", 32'(ov1), 32'h0);
        check("hold_ov8", 32'(ov8), 32'h0);
        #1;
        check("comb_idle_valid", 32'(ovc), 32'h0);
        check("comb_idle_out", 32'(outc), 32'h0);
        step();
        check("hold2_out1", 32'(out1), 32'h1);

        // Reset mid-stream overrides a qualified input, then release.
        in_valid = 1'b1;
        sel      = 2'b11;
        data1    = 4'b1000;
        step();
        check("pre_rst_out1", 32'(out1), 32'h1);
        rst = 1'b1;
        step();
        check("mid_rst_out1", 32'(out1), 32'h0);
        check("mid_rst_ov1", 32'(ov1), 32'h0);
        check("mid_rst_out8", 32'(out8), 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_out1", 32'(out1), 32'h1);
        check("post_rst_ov1", 32'(ov1), 32'h1);
        check("post_rst_out8", 32'(out8), 32'hDD);

        // Combinational variant ignores clock and reset.
        rst   = 1'b1;
        datac = 4'b0100;
        sel   = 2'b10;
        #1;
        check("comb_now_out", 32'(outc), 32'h1);
        step();
        check("comb_edge_out", 32'(outc), 32'h1);
        sel = 2'b11;
        #1;
        check("comb_lane3_out", 32'(outc), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_4x1.md
MUX_4X1 -- requirements
Module: mux_4x1

Interface
REQ-001 Parameter: LANE_W, 1, width in bits of each of the four input lanes and of the output.
REQ-002 Parameter: REG_OUT, 1, 1 = registered output (1-cycle latency); 0 = purely combinational output.
REQ-003 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port: data  input  4*LANE_W  four packed lanes; lane k = data[k*LANE_W +: LANE_W], lane 0 at LSBs.
REQ-006 Port: sel  input  2  lane select, unsigned binary 0..3.
REQ-007 Port: in_valid  input  1  qualifies data/sel in the current cycle.
REQ-008 Port: out  output  LANE_W  selected lane.
REQ-009 Port: out_valid  output  1  out holds a result for a qualified input.

Function
REQ-010 Selected lane SHALL be lane number sel: 2'b00->lane0, 2'b01->lane1, 2'b10->lane2, 2'b11->lane3.
REQ-011 Selection SHALL be a two-level 2:1 tree: sel[0] picks within pairs (0/1, 2/3), sel[1] picks between pair results.
REQ-012 With REG_OUT=1, out SHALL update on the rising edge where in_valid=1 to the lane selected by the data/sel sampled at that edge; latency exactly 1 cycle.
REQ-013 With REG_OUT=1 and in_valid=0, out SHALL hold its previous value.
REQ-014 With REG_OUT=1, out_valid SHALL be a registered copy of in_valid (1-cycle latency, same edge as out).
REQ-015 With REG_OUT=0, out SHALL follow data/sel combinationally in the same cycle regardless of in_valid, and out_valid SHALL equal in_valid combinationally.
REQ-016 No handshake back-pressure: a new qualified input SHALL be accepted every cycle (throughput 1/cycle).
REQ-017 Changing sel with data constant SHALL change out no later than the next qualified edge (REG_OUT=1) or immediately (REG_OUT=0).
REQ-018 Unknown/X on sel SHALL NOT be specially handled; no out-of-range case exists (2-bit sel covers all 4 lanes).

Reset
REQ-019 While rst=1 at a rising edge, out SHALL become all zeros and out_valid SHALL become 0, overriding in_valid.
REQ-020 Reset SHALL take priority over a simultaneous in_valid=1; that input is discarded.
REQ-021 The first qualified input after rst deasserts SHALL produce out/out_valid one cycle later (REG_OUT=1).
REQ-022 With REG_OUT=0, rst SHALL have no effect on out (no state exists).

Structure
REQ-023 A shared package SHALL hold the select-encoding constants SEL_LANE0..SEL_LANE3 (2'd0..2'd3) and the lane-count constant NUM_LANES=4.
REQ-024 One sub-module, mux_2x1 (parameterised by LANE_W; inputs a, b, s; output y = s ? b : a), SHALL be instantiated three times to form the tree.
REQ-025 The output register and valid register SHALL live in mux_4x1 under a generate on REG_OUT.

Verification
REQ-026 rst=1 for 2 cycles with data=4'b1111, in_valid=1 -> out=0, out_valid=0 throughout.
REQ-027 LANE_W=1, data=4'b1010, in_valid=1, sel stepped 00,01,10,11 one per cycle -> out 0,1,0,1 each one cycle later; out_valid=1.
REQ-028 data=4'b1010, sel=2'b01, in_valid pulsed for 1 cycle then 0, sel changed to 00 -> out stays 1, out_valid drops to 0.
REQ-029 LANE_W=8, data=32'hDDCCBBAA, sel 0..3 -> out 8'hAA, 8'hBB, 8'hCC, 8'hDD.
REQ-030 rst asserted mid-stream with in_valid=1, sel=2'b11, data=4'b1000 -> next cycle out=0, out_valid=0; after release, result 1 appears one cycle later.
REQ-031 REG_OUT=0, data=4'b0100, sel=2'b10 -> out=1 in the same cycle, independent of clk and rst.
